// File: rtl/zorro2_autoconfig_chain.sv
// Zorro II AutoConfig engine: offers NUM_FUNCS logical boards one at a time
// in the $E80000 config space, captures their assigned bases, decodes hits
// per function and drives the downstream chain-out once all are resolved.
module zorro2_autoconfig_chain #(
  parameter int                         NUM_FUNCS    = 3,
  parameter logic [8*NUM_FUNCS-1:0]     FUNC_ER_TYPE = {8'hC1, 8'hD1, 8'hE0},
  parameter logic [8*NUM_FUNCS-1:0]     FUNC_PROD    = {8'h4A, 8'h49, 8'h48},
  parameter logic [8*NUM_FUNCS-1:0]     FUNC_FLAGS   = {8'h00, 8'h00, 8'h80},
  parameter logic [16*NUM_FUNCS-1:0]    FUNC_MFG     = {16'h07DB, 16'h082C, 16'h07DB},
  parameter logic [16*NUM_FUNCS-1:0]    FUNC_ROMVEC  = {16'h0000, 16'h0008, 16'h0000},
  parameter logic [31:0]                SERIAL       = 32'd421
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic [23:1]              ADDR,
  input  logic                     AS_n,
  input  logic                     RW,
  input  logic [3:0]               DIN,
  input  logic                     bus_data,
  input  logic                     cfgin,
  input  logic [NUM_FUNCS-1:0]     func_en,
  output logic [3:0]               DOUT,
  output logic                     dtack,
  output logic                     autoconfig_cycle,
  output logic                     cfgout_n,
  output logic [NUM_FUNCS-1:0]     func_hit,
  output logic [8*NUM_FUNCS-1:0]   func_base
);

  typedef enum logic [1:0] {SEEK, OFFER, DONE} state_t;

  // Size code to number of 64K units; code 0 is the 8MB board.
  function automatic logic [8:0] size_units(input logic [2:0] code);
    if (code == 3'd0) size_units = 9'd128;
    else              size_units = 9'd1 << (code - 3'd1);
  endfunction

  state_t                r_state;
  logic [3:0]            r_idx;
  logic [3:0]            r_base_lo;
  logic [7:0]            r_base [NUM_FUNCS];
  logic [NUM_FUNCS-1:0]  r_cfg;
  logic [NUM_FUNCS-1:0]  r_shut;
  logic [3:0]            r_dout;
  logic                  r_dtack;
  logic                  r_acked;
  logic                  r_as_s1, r_as_s2, r_as_s3;
  logic                  r_cfgout_n;

  logic [7:0]            w_er, w_prod, w_flags;
  logic [15:0]           w_mfg, w_romvec;
  logic                  w_en_cur;
  logic [3:0]            w_rd_nib;
  logic                  w_access;
  logic                  w_unused;

  // A15..A9 play no part in config-space decode.
  assign w_unused = ^ADDR[15:9];

  assign autoconfig_cycle = (ADDR[23:16] == 8'hE8) && cfgin && r_cfgout_n && (r_state == OFFER);
  // One acknowledge per data phase: r_acked holds off re-triggering until bus_data drops.
  assign w_access = bus_data && autoconfig_cycle && !r_dtack && !r_acked;

  assign DOUT     = r_dout;
  assign dtack    = r_dtack;
  assign cfgout_n = r_cfgout_n;

  // Pick out the descriptor of the function currently addressed by r_idx.
  always_comb begin
    w_er     = '0;
    w_prod   = '0;
    w_flags  = '0;
    w_mfg    = '0;
    w_romvec = '0;
    w_en_cur = 1'b0;
    for (int i = 0; i < NUM_FUNCS; i++) begin
      if (r_idx == 4'(i)) begin
        w_er     = FUNC_ER_TYPE[8*i +: 8];
        w_prod   = FUNC_PROD[8*i +: 8];
        w_flags  = FUNC_FLAGS[8*i +: 8];
        w_mfg    = FUNC_MFG[16*i +: 16];
        w_romvec = FUNC_ROMVEC[16*i +: 16];
        w_en_cur = func_en[i];
      end
    end
  end

  // Config ROM image: only ER_TYPE is presented true, everything else inverted.
  always_comb begin
    w_rd_nib = 4'hF;
    case (ADDR[8:1])
      8'h00: w_rd_nib = w_er[7:4];
      8'h01: w_rd_nib = w_er[3:0];
      8'h02: w_rd_nib = ~w_prod[7:4];
      8'h03: w_rd_nib = ~w_prod[3:0];
      8'h04: w_rd_nib = ~w_flags[7:4];
      8'h05: w_rd_nib = ~w_flags[3:0];
      8'h08: w_rd_nib = ~w_mfg[15:12];
      8'h09: w_rd_nib = ~w_mfg[11:8];
      8'h0A: w_rd_nib = ~w_mfg[7:4];
      8'h0B: w_rd_nib = ~w_mfg[3:0];
      8'h0C: w_rd_nib = ~SERIAL[31:28];
      8'h0D: w_rd_nib = ~SERIAL[27:24];
      8'h0E: w_rd_nib = ~SERIAL[23:20];
      8'h0F: w_rd_nib = ~SERIAL[19:16];
      8'h10: w_rd_nib = ~SERIAL[15:12];
      8'h11: w_rd_nib = ~SERIAL[11:8];
      8'h12: w_rd_nib = ~SERIAL[7:4];
      8'h13: w_rd_nib = ~SERIAL[3:0];
      8'h14: w_rd_nib = ~w_romvec[15:12];
      8'h15: w_rd_nib = ~w_romvec[11:8];
      8'h16: w_rd_nib = ~w_romvec[7:4];
      8'h17: w_rd_nib = ~w_romvec[3:0];
      8'h20: w_rd_nib = 4'h0;
      8'h21: w_rd_nib = 4'h0;
      default: w_rd_nib = 4'hF;
    endcase
  end

  // Chain FSM plus bus acknowledge, read data and base capture.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= SEEK;
      r_idx     <= 4'd0;
      r_base_lo <= 4'd0;
      r_cfg     <= '0;
      r_shut    <= '0;
      r_dout    <= 4'd0;
      r_dtack   <= 1'b0;
      r_acked   <= 1'b0;
      for (int i = 0; i < NUM_FUNCS; i++) r_base[i] <= 8'd0;
    end else begin
      r_dtack <= w_access;
      if (!bus_data)     r_acked <= 1'b0;
      else if (w_access) r_acked <= 1'b1;
      if (w_access && RW) r_dout <= w_rd_nib;

      case (r_state)
        SEEK: begin
          if (r_idx == 4'(NUM_FUNCS)) begin
            r_state <= DONE;
          end else if (w_en_cur) begin
            r_state <= OFFER;
          end else begin
            r_idx     <= r_idx + 4'd1;
            r_base_lo <= 4'd0;
          end
        end
        OFFER: begin
          if (w_access && !RW) begin
            case (ADDR[8:1])
              8'h24: begin
                for (int i = 0; i < NUM_FUNCS; i++) begin
                  if (r_idx == 4'(i)) begin
                    r_base[i] <= {DIN, r_base_lo};
                    r_cfg[i]  <= 1'b1;
                  end
                end
                r_idx     <= r_idx + 4'd1;
                r_base_lo <= 4'd0;
                r_state   <= SEEK;
              end
              8'h25: r_base_lo <= DIN;
              8'h26: begin
                for (int i = 0; i < NUM_FUNCS; i++) begin
                  if (r_idx == 4'(i)) r_shut[i] <= 1'b1;
                end
                r_idx     <= r_idx + 4'd1;
                r_base_lo <= 4'd0;
                r_state   <= SEEK;
              end
              default: ;
            endcase
          end
        end
        DONE: ;
        default: r_state <= SEEK;
      endcase
    end
  end

  // Chain-out only changes at the end of a bus cycle (synchronised AS_n rising edge).
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_as_s1    <= 1'b1;
      r_as_s2    <= 1'b1;
      r_as_s3    <= 1'b1;
      r_cfgout_n <= 1'b1;
    end else begin
      r_as_s1 <= AS_n;
      r_as_s2 <= r_as_s1;
      r_as_s3 <= r_as_s2;
      if (r_as_s2 && !r_as_s3) r_cfgout_n <= !(r_state == DONE);
    end
  end

  // Per-function window decode; the difference form cannot wrap past $FF.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FUNCS; gi++) begin : g_func
      logic [7:0] w_diff;
      assign w_diff = ADDR[23:16] - r_base[gi];
      assign func_hit[gi] = r_cfg[gi] && !r_shut[gi] &&
                            (ADDR[23:16] >= r_base[gi]) &&
                            ({1'b0, w_diff} < size_units(FUNC_ER_TYPE[8*gi +: 3]));
      assign func_base[8*gi +: 8] = r_base[gi];
    end
  endgenerate

endmodule

// File: tb/tb_zorro2_autoconfig_chain.sv
// Bench for zorro2_autoconfig_chain: directed walk through the configuration
// sequence followed by randomized bus traffic, all checked against a
// descriptor-table model of the AutoConfig chain.
module tb_zorro2_autoconfig_chain;

  localparam int NF = 3;

  logic          CLK;
  logic          RESET_n;
  logic [23:1]   ADDR;
  logic          AS_n;
  logic          RW;
  logic [3:0]    DIN;
  logic          bus_data;
  logic          cfgin;
  logic [NF-1:0] func_en;
  logic [3:0]    DOUT;
  logic          dtack;
  logic          autoconfig_cycle;
  logic          cfgout_n;
  logic [NF-1:0] func_hit;
  logic [8*NF-1:0] func_base;

  zorro2_autoconfig_chain dut (
    .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .AS_n(AS_n), .RW(RW), .DIN(DIN),
    .bus_data(bus_data), .cfgin(cfgin), .func_en(func_en), .DOUT(DOUT),
    .dtack(dtack), .autoconfig_cycle(autoconfig_cycle), .cfgout_n(cfgout_n),
    .func_hit(func_hit), .func_base(func_base)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Descriptor tables, function 0 first.
  logic [7:0]  er_t   [NF] = '{8'hE0, 8'hD1, 8'hC1};
  logic [7:0]  prod_t [NF] = '{8'h48, 8'h49, 8'h4A};
  logic [7:0]  flag_t [NF] = '{8'h80, 8'h00, 8'h00};
  logic [15:0] mfg_t  [NF] = '{16'h07DB, 16'h082C, 16'h07DB};
  logic [15:0] rom_t  [NF] = '{16'h0000, 16'h0008, 16'h0000};
  logic [31:0] serial_v = 32'd421;

  // Reference model state.
  logic [7:0]    m_base [NF];
  logic [NF-1:0] m_cfg;
  logic [NF-1:0] m_en;
  logic [3:0]    m_lo;
  logic [3:0]    m_dout;
  logic          m_cfgout;
  int            m_cur;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_en(input int start);
    for (int k = start; k < NF; k++) if (m_en[k]) return k;
    return NF;
  endfunction

  function automatic int units(input int f);
    int code;
    code = int'(er_t[f][2:0]);
    return (code == 0) ? 128 : (1 << (code - 1));
  endfunction

  // Nibble a host reads back at a given config offset.
  function automatic logic [3:0] exp_nib(input int f, input logic [7:0] off);
    int k;
    if (off == 8'h00) return er_t[f][7:4];
    if (off == 8'h01) return er_t[f][3:0];
    if (off == 8'h02) return ~prod_t[f][7:4];
    if (off == 8'h03) return ~prod_t[f][3:0];
    if (off == 8'h04) return ~flag_t[f][7:4];
    if (off == 8'h05) return ~flag_t[f][3:0];
    if (off >= 8'h08 && off <= 8'h0B) begin
      k = int'(off) - 8;
      return ~4'(mfg_t[f] >> (12 - 4*k));
    end
    if (off >= 8'h0C && off <= 8'h13) begin
      k = int'(off) - 12;
      return ~4'(serial_v >> (28 - 4*k));
    end
    if (off >= 8'h14 && off <= 8'h17) begin
      k = int'(off) - 20;
      return ~4'(rom_t[f] >> (12 - 4*k));
    end
    if (off == 8'h20 || off == 8'h21) return 4'h0;
    return 4'hF;
  endfunction

  function automatic logic [8*NF-1:0] exp_bases();
    logic [8*NF-1:0] v;
    for (int i = 0; i < NF; i++) v[8*i +: 8] = m_base[i];
    return v;
  endfunction

  task automatic do_reset(input logic [NF-1:0] en);
    @(negedge CLK);
    RESET_n = 1'b0; func_en = en; AS_n = 1'b1; bus_data = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_dout",   32'(DOUT), 32'h0);
    check("rst_dtack",  32'(dtack), 32'h0);
    check("rst_cfgout", 32'(cfgout_n), 32'h1);
    check("rst_base",   32'(func_base), 32'h0);
    check("rst_hit",    32'(func_hit), 32'h0);
    for (int i = 0; i < NF; i++) m_base[i] = 8'h00;
    m_cfg = '0; m_en = en; m_lo = 4'h0; m_dout = 4'h0; m_cfgout = 1'b1;
    m_cur = next_en(0);
    RESET_n = 1'b1;
    repeat (NF + 2) @(negedge CLK);
  endtask

  // One complete Zorro bus cycle against the config space.
  task automatic xfer(input logic [7:0] hi, input logic [7:0] off, input logic rw,
                      input logic [3:0] din, output logic [3:0] dout_seen);
    logic claim, acked;
    int   c;
    ADDR = {hi, 7'd0, off}; RW = rw; DIN = din; AS_n = 1'b0;
    claim = (hi == 8'hE8) && cfgin && m_cfgout && (m_cur < NF);
    @(negedge CLK);
    check("acyc", 32'(autoconfig_cycle), 32'(claim));
    bus_data = 1'b1;
    acked = 1'b0;
    c = 0;
    while (!acked && c < 8) begin
      @(negedge CLK);
      if (dtack) acked = 1'b1;
      c++;
    end
    if (acked) begin
      @(negedge CLK);
      check("dtack_1clk", 32'(dtack), 32'h0);
    end
    bus_data = 1'b0;
    check("ack", 32'(acked), 32'(claim));
    if (claim) begin
      if (rw) begin
        m_dout = exp_nib(m_cur, off);
      end else if (off == 8'h24) begin
        m_base[m_cur] = {din, m_lo};
        m_cfg[m_cur]  = 1'b1;
        m_lo  = 4'h0;
        m_cur = next_en(m_cur + 1);
      end else if (off == 8'h26) begin
        m_lo  = 4'h0;
        m_cur = next_en(m_cur + 1);
      end else if (off == 8'h25) begin
        m_lo = din;
      end
    end
    check("dout", 32'(DOUT), 32'(m_dout));
    dout_seen = DOUT;
    repeat (5) @(negedge CLK);
    check("cfgout_hold", 32'(cfgout_n), 32'(m_cfgout));
    AS_n = 1'b1;
    m_cfgout = (m_cur != NF);
    repeat (6) @(negedge CLK);
    check("cfgout", 32'(cfgout_n), 32'(m_cfgout));
    check("base", 32'(func_base), 32'(exp_bases()));
    $display("txn hi=%h off=%h rw=%0d din=%h ack=%0d dout=%h cfgout_n=%0d",
             hi, off, rw, din, acked, DOUT, cfgout_n);
  endtask

  task automatic hit_at(input string tag, input logic [7:0] hi, input int f, input logic exp);
    ADDR = {hi, 15'd0};
    #1;
    check(tag, 32'(func_hit[f]), 32'(exp));
  endtask

  // Sweep every 64K page and compare all hit lines with the model windows.
  task automatic sweep_hits(input string tag);
    logic [NF-1:0] e;
    int b;
    for (int a = 0; a < 256; a++) begin
      ADDR = {8'(a), 15'd0};
      #1;
      for (int i = 0; i < NF; i++) begin
        b = int'(m_base[i]);
        e[i] = m_cfg[i] && (a >= b) && (a < b + units(i));
      end
      check(tag, 32'(func_hit), 32'(e));
    end
    @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] d;
    logic [7:0] hi, off;
    logic rw;
    int sel;

    RESET_n = 1'b0; ADDR = '0; AS_n = 1'b1; RW = 1'b1; DIN = 4'h0;
    bus_data = 1'b0; cfgin = 1'b1; func_en = '1;

    // Function 0 offered first; configure at $200000 (8MB window).
    do_reset(3'b111);
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p1_er_hi", 32'(d), 32'hE);
    xfer(8'hE8, 8'h01, 1'b1, 4'h0, d); check("p1_er_lo", 32'(d), 32'h0);
    xfer(8'hE8, 8'h02, 1'b1, 4'h0, d); check("p1_prod",  32'(d), 32'hB);
    xfer(8'hE8, 8'h24, 1'b0, 4'h2, d);
    check("p1_base0", 32'(func_base[7:0]), 32'h20);
    hit_at("p1_hit20", 8'h20, 0, 1'b1);
    hit_at("p1_hit9F", 8'h9F, 0, 1'b1);
    hit_at("p1_hitA0", 8'hA0, 0, 1'b0);
    hit_at("p1_hit1F", 8'h1F, 0, 1'b0);

    // Function 1: manufacturer nibbles, two-nibble base at $E90000.
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p3_er_hi", 32'(d), 32'hD);
    xfer(8'hE8, 8'h08, 1'b1, 4'h0, d); check("p3_mfg0", 32'(d), 32'hF);
    xfer(8'hE8, 8'h09, 1'b1, 4'h0, d); check("p3_mfg1", 32'(d), 32'h7);
    xfer(8'hE8, 8'h0A, 1'b1, 4'h0, d); check("p3_mfg2", 32'(d), 32'hD);
    xfer(8'hE8, 8'h0B, 1'b1, 4'h0, d); check("p3_mfg3", 32'(d), 32'h3);
    xfer(8'hE8, 8'h25, 1'b0, 4'h9, d);
    xfer(8'hE8, 8'h24, 1'b0, 4'hE, d);
    check("p3_base1", 32'(func_base[15:8]), 32'hE9);
    hit_at("p3_hitE9", 8'hE9, 1, 1'b1);
    hit_at("p3_hitEA", 8'hEA, 1, 1'b0);
    hit_at("p3_hitE8", 8'hE8, 1, 1'b0);

    // Function 2 shut up: chain completes only after the bus cycle ends.
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p4_er_hi", 32'(d), 32'hC);
    xfer(8'hE8, 8'h26, 1'b0, 4'h0, d);
    check("p4_cfgout", 32'(cfgout_n), 32'h0);
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d);
    sweep_hits("p4_sweep");

    // Function 0 disabled at runtime: function 1 appears first.
    do_reset(3'b110);
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p2_er_hi", 32'(d), 32'hD);

    // cfgin low: no claim, DOUT held; then normal after raising cfgin.
    do_reset(3'b111);
    cfgin = 1'b0;
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p5_held", 32'(d), 32'h0);
    cfgin = 1'b1;
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p5_er_hi", 32'(d), 32'hE);

    // Reset after function 0 configured wipes everything.
    xfer(8'hE8, 8'h24, 1'b0, 4'h5, d);
    hit_at("p6_pre", 8'h50, 0, 1'b1);
    do_reset(3'b111);
    sweep_hits("p6_sweep");
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d); check("p6_er_hi", 32'(d), 32'hE);

    // All functions disabled: straight to DONE, never claims.
    do_reset(3'b000);
    xfer(8'hE8, 8'h00, 1'b1, 4'h0, d);
    check("alloff_cfgout", 32'(cfgout_n), 32'h0);

    // Randomized sequences.
    for (int r = 0; r < 20; r++) begin
      do_reset(NF'($urandom));
      cfgin = 1'b1;
      for (int t = 0; t < 15; t++) begin
        if ($urandom_range(0, 9) == 0) cfgin = ~cfgin;
        hi  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hE8;
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      off = 8'(8'h24 + $urandom_range(0, 2));
        else if (sel == 1) off = 8'($urandom);
        else               off = 8'($urandom_range(0, 8'h22));
        rw = (sel == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        xfer(hi, off, rw, 4'($urandom), d);
      end
      sweep_hits("rnd_sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
